mvm_job_sequencer: RTL and testbench
====================================

MVM_JOB_SEQUENCER -- requirements
Module: mvm_job_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, meaning matrix dimension (rows of A = length of B = result words).
REQ-002 SHALL have parameter DW, default 8, meaning operand byte width; CW, default 24, meaning result width.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  job request pulse; busy  out  1  high whenever state != IDLE; job_done  out  1  one-cycle pulse at job end.
REQ-006 in_valid  in  1; in_data  in  DW; in_ready  out  1  operand byte stream: N*N A bytes row-major, then N B bytes.
REQ-007 a_wren  out  N  one-hot row FIFO write; a_data  out  N x DW  all lanes = in_data; b_wren  out  1; b_data  out  DW  = in_data.
REQ-008 a_full  in  N; b_full  in  1  FIFO full flags from MVM datapath.
REQ-009 mvm_rst_n  out  1  active-low reset to MVM datapath; mvm_done  in  1; mvm_c  in  N x CW  MVM results.
REQ-010 out_valid  out  1; out_data  out  CW; out_last  out  1; out_ready  in  1  result stream, row 0 first.

Function
REQ-011 SHALL implement states IDLE, CLEAR, LOAD_A, LOAD_B, WAIT_DONE, DRAIN.
REQ-012 IDLE: start=1 -> CLEAR next cycle; start outside IDLE SHALL be ignored.
REQ-013 CLEAR: mvm_rst_n=0 for exactly 2 cycles, then LOAD_A; mvm_rst_n=1 in all other states.
REQ-014 in_ready SHALL be 1 only in LOAD_A with !a_full[row] or LOAD_B with !b_full (combinational on flags).
REQ-015 Accept = in_valid & in_ready; on accept in LOAD_A, a_wren[row]=1 same cycle, all other a_wren bits 0; row = byte_idx / N.
REQ-016 byte_idx (0..N*N-1) SHALL increment per accept; accept at N*N-1 -> LOAD_B, byte_idx cleared.
REQ-017 On accept in LOAD_B, b_wren=1 same cycle; Nth B accept -> WAIT_DONE.
REQ-018 No write strobe SHALL be asserted without an accept; in_valid=1 with target full SHALL stall (no drop, no write).
REQ-019 WAIT_DONE: on mvm_done=1, mvm_c SHALL be captured into result buffer at that edge and state -> DRAIN.
REQ-020 DRAIN: out_valid=1, out_data=buf[out_idx], out_last=(out_idx==N-1); out_idx increments on out_valid&out_ready.
REQ-021 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Handshake with out_last=1 -> IDLE, job_done=1 for that following cycle only.
REQ-023 Result buffer SHALL not be overwritten after capture until next job's WAIT_DONE capture.
REQ-024 Indices SHALL be sized $clog2 of range; no wrap beyond terminal values.

Reset
REQ-025 rst=1 at any edge, including mid-job: state=IDLE, counters=0, busy=0, job_done=0, in_ready=0, a_wren=0, b_wren=0, out_valid=0, out_last=0, mvm_rst_n=0.
REQ-026 mvm_rst_n SHALL be 0 while rst=1 and return to 1 the cycle after rst deasserts; result buffer contents need not reset.

Structure
REQ-027 Shared package mvm_pkg SHALL hold N, DW, CW constants and the sequencer state enum type.
REQ-028 One sub-module mvm_result_buf (N x CW capture registers, capture enable, read index mux) SHALL be used; FSM and counters stay in top.

Verification
REQ-029 Full job, no backpressure: A[i][j]=i+j+1, B[j]=j+1; model MVM responds -> 8 out words = sum_j (i+j+1)(j+1), out_last on word 7, job_done once.
REQ-030 Stream with in_valid gaps and a_full[3] forced 1 for 5 cycles during row 3 -> in_ready=0 those cycles, no a_wren, row 3 gets exactly 8 bytes in order.
REQ-031 out_ready toggled 1-0-0-1 pattern -> out_data stable while stalled, 8 words in order, no duplication.
REQ-032 start pulsed during LOAD_A and DRAIN -> ignored; start in IDLE -> mvm_rst_n low exactly 2 cycles.
REQ-033 rst asserted in LOAD_A after 20 bytes -> IDLE next cycle, all outputs at reset values; subsequent full job correct.
REQ-034 Max values: all bytes 255 -> each out word 8*65025=520200, no truncation in CW.

Source files
------------

// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared MVM dimensions and job sequencer state type
package mvm_pkg;

    localparam int MVM_N  = 8;
    localparam int MVM_DW = 8;
    localparam int MVM_CW = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_WAIT_DONE,
        ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/mvm_result_buf.sv
// rtl/mvm_result_buf.sv - result capture registers with indexed read
module mvm_result_buf
    import mvm_pkg::*;
#(
    parameter int N  = MVM_N,
    parameter int CW = MVM_CW,
    parameter int IW = $clog2(MVM_N)
) (
    input  logic                  clk,
    input  logic                  i_cap_en,
    input  logic [N-1:0][CW-1:0]  i_cap_data,
    input  logic [IW-1:0]         i_rd_idx,
    output logic [CW-1:0]         o_rd_data
);

    // Contents persist across jobs and are only replaced on the next capture.
    logic [N-1:0][CW-1:0] r_buf;

    always_ff @(posedge clk) begin
        if (i_cap_en) begin
            r_buf <= i_cap_data;
        end
    end

    assign o_rd_data = r_buf[i_rd_idx];

endmodule

// File: rtl/mvm_job_sequencer.sv
// rtl/mvm_job_sequencer.sv - loads A/B operands into the MVM datapath and drains its results
module mvm_job_sequencer
    import mvm_pkg::*;
#(
    parameter int N  = MVM_N,
    parameter int DW = MVM_DW,
    parameter int CW = MVM_CW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  job_done,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    output logic [N-1:0]          a_wren,
    output logic [N-1:0][DW-1:0]  a_data,
    output logic                  b_wren,
    output logic [DW-1:0]         b_data,
    input  logic [N-1:0]          a_full,
    input  logic                  b_full,
    output logic                  mvm_rst_n,
    input  logic                  mvm_done,
    input  logic [N-1:0][CW-1:0]  mvm_c,
    output logic                  out_valid,
    output logic [CW-1:0]         out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int NN = N * N;
    localparam int BW = $clog2(NN);
    localparam int RW = $clog2(N);

    seq_state_e      r_state;
    seq_state_e      w_next;
    logic [BW-1:0]   r_byte_idx;
    logic [RW-1:0]   r_b_idx;
    logic [RW-1:0]   r_out_idx;
    logic            r_clr_cnt;
    logic            r_job_done;
    logic            r_rst_q;

    logic [RW-1:0]   w_row;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_a_last;
    logic            w_b_last;
    logic            w_out_hs;
    logic            w_out_last_idx;
    logic            w_capture;
    logic [CW-1:0]   w_buf_data;

    assign w_row          = RW'(r_byte_idx / BW'(N));
    assign w_in_ready     = ((r_state == ST_LOAD_A) && !a_full[w_row]) ||
                            ((r_state == ST_LOAD_B) && !b_full);
    assign w_accept       = in_valid && w_in_ready;
    assign w_a_last       = (r_byte_idx == BW'(NN - 1));
    assign w_b_last       = (r_b_idx == RW'(N - 1));
    assign w_out_last_idx = (r_out_idx == RW'(N - 1));
    assign w_out_hs       = (r_state == ST_DRAIN) && out_ready;
    assign w_capture      = (r_state == ST_WAIT_DONE) && mvm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (start)                        w_next = ST_CLEAR;
            ST_CLEAR:     if (r_clr_cnt)                    w_next = ST_LOAD_A;
            ST_LOAD_A:    if (w_accept && w_a_last)         w_next = ST_LOAD_B;
            ST_LOAD_B:    if (w_accept && w_b_last)         w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (mvm_done)                     w_next = ST_DRAIN;
            ST_DRAIN:     if (w_out_hs && w_out_last_idx)   w_next = ST_IDLE;
            default:                                        w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        job_done  = r_job_done;
        in_ready  = w_in_ready;
        a_wren    = '0;
        if ((r_state == ST_LOAD_A) && w_accept) begin
            a_wren[w_row] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            a_data[i] = in_data;
        end
        b_wren    = (r_state == ST_LOAD_B) && w_accept;
        b_data    = in_data;
        mvm_rst_n = !r_rst_q && (r_state != ST_CLEAR);
        out_valid = (r_state == ST_DRAIN);
        out_data  = w_buf_data;
        out_last  = (r_state == ST_DRAIN) && w_out_last_idx;
    end

    // Counters return to zero at their terminal value rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx <= '0;
            r_b_idx    <= '0;
            r_out_idx  <= '0;
            r_clr_cnt  <= 1'b0;
            r_job_done <= 1'b0;
            r_rst_q    <= 1'b1;
        end else begin
            r_rst_q    <= 1'b0;
            r_job_done <= w_out_hs && w_out_last_idx;
            case (r_state)
                ST_IDLE: begin
                    r_byte_idx <= '0;
                    r_b_idx    <= '0;
                    r_out_idx  <= '0;
                    r_clr_cnt  <= 1'b0;
                end
                ST_CLEAR: begin
                    r_clr_cnt <= ~r_clr_cnt;
                end
                ST_LOAD_A: begin
                    if (w_accept) begin
                        r_byte_idx <= w_a_last ? '0 : r_byte_idx + BW'(1);
                    end
                end
                ST_LOAD_B: begin
                    if (w_accept) begin
                        r_b_idx <= w_b_last ? '0 : r_b_idx + RW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_out_hs) begin
                        r_out_idx <= w_out_last_idx ? '0 : r_out_idx + RW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    mvm_result_buf #(
        .N  (N),
        .CW (CW),
        .IW (RW)
    ) u_result_buf (
        .clk        (clk),
        .i_cap_en   (w_capture),
        .i_cap_data (mvm_c),
        .i_rd_idx   (r_out_idx),
        .o_rd_data  (w_buf_data)
    );

endmodule

// File: tb/tb_mvm_job_sequencer.sv
// tb/tb_mvm_job_sequencer.sv - randomized job bench with job-level reference model
module tb_mvm_job_sequencer;
    import mvm_pkg::*;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int CW  = 24;
    localparam int NN  = N * N;
    localparam int TOT = NN + N;

    logic                 clk = 1'b0;
    logic                 rst, start, in_valid, b_full, mvm_done, out_ready;
    logic [DW-1:0]        in_data;
    logic [N-1:0]         a_full;
    logic [N-1:0][CW-1:0] mvm_c;
    logic                 busy, job_done, in_ready, b_wren, mvm_rst_n, out_valid, out_last;
    logic [N-1:0]         a_wren;
    logic [N-1:0][DW-1:0] a_data;
    logic [DW-1:0]        b_data;
    logic [CW-1:0]        out_data;

    mvm_job_sequencer #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .job_done(job_done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .a_wren(a_wren), .a_data(a_data), .b_wren(b_wren), .b_data(b_data),
        .a_full(a_full), .b_full(b_full), .mvm_rst_n(mvm_rst_n), .mvm_done(mvm_done),
        .mvm_c(mvm_c), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Job-level model: counts of accepted bytes and drained words, not RTL states.
    bit     m_init = 0, m_active = 0, m_rst_q = 0, m_have_res = 0, m_jd = 0;
    int     m_clear = 0, m_acc = 0, m_drn = 0;
    int     m_a[N][N];
    int     m_b[N];
    longint m_res[N];
    int     stim[TOT];

    function automatic bit m_ready();
        if (!m_active || m_clear > 0) return 1'b0;
        if (m_acc < NN)  return !a_full[m_acc / N];
        if (m_acc < TOT) return !b_full;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        acc = in_valid && m_ready();
        if (rst) begin
            m_init = 1; m_active = 0; m_clear = 0; m_acc = 0; m_drn = 0;
            m_have_res = 0; m_jd = 0; m_rst_q = 1;
        end else if (m_init) begin
            m_rst_q = 0;
            m_jd    = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_clear = 2; m_acc = 0; m_have_res = 0; m_drn = 0;
                end
            end else if (m_clear > 0) begin
                m_clear--;
            end else if (m_acc < TOT) begin
                if (acc) begin
                    if (m_acc < NN) m_a[m_acc / N][m_acc % N] = int'(in_data);
                    else            m_b[m_acc - NN] = int'(in_data);
                    m_acc++;
                    if (m_acc == TOT) begin
                        for (int i = 0; i < N; i++) begin
                            m_res[i] = 0;
                            for (int j = 0; j < N; j++) m_res[i] += longint'(m_a[i][j]) * longint'(m_b[j]);
                        end
                    end
                end
            end else if (!m_have_res) begin
                if (mvm_done) begin
                    m_have_res = 1; m_drn = 0;
                end
            end else if (out_ready) begin
                if (m_drn == N - 1) begin
                    m_active = 0; m_have_res = 0; m_jd = 1;
                end else begin
                    m_drn++;
                end
            end
        end
    end

    // MVM datapath stand-in: row FIFOs filled by the sequencer's write strobes.
    logic [DW-1:0] fa[N][$];
    logic [DW-1:0] fb[$];

    always @(posedge clk) begin
        if (!mvm_rst_n) begin
            for (int i = 0; i < N; i++) fa[i].delete();
            fb.delete();
        end else begin
            for (int i = 0; i < N; i++) if (a_wren[i]) fa[i].push_back(a_data[i]);
            if (b_wren) fb.push_back(b_data);
        end
    end

    int            jd_cnt = 0, low_cnt = 0;
    logic [CW-1:0] got[$];

    always @(negedge clk) begin
        if (m_init) begin
            logic [N-1:0] ew;
            bit           ld_a, ld_b;
            ld_a = m_active && m_clear == 0 && m_acc < NN;
            ld_b = m_active && m_clear == 0 && m_acc >= NN && m_acc < TOT;
            ew   = '0;
            if (ld_a && in_valid && m_ready()) ew[m_acc / N] = 1'b1;
            chk("busy", busy, m_active);
            chk("in_ready", in_ready, m_ready());
            chk("a_wren", a_wren, ew);
            chk("b_wren", b_wren, ld_b && in_valid && m_ready());
            chk("mvm_rst_n", mvm_rst_n, !m_rst_q && !(m_active && m_clear > 0));
            chk("out_valid", out_valid, m_have_res);
            chk("out_last", out_last, m_have_res && m_drn == N - 1);
            chk("job_done", job_done, m_jd);
            if (m_have_res) chk("out_data", out_data, m_res[m_drn]);
            for (int i = 0; i < N; i++) chk("a_data_lane", a_data[i], in_data);
            chk("b_data", b_data, in_data);
            if (job_done) jd_cnt++;
            if (!mvm_rst_n && !rst) low_cnt++;
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_c();
        for (int i = 0; i < N; i++) mvm_c[i] = CW'($urandom);
    endtask

    // kind: 0 = arithmetic pattern, 1 = random bytes, 2 = all 255
    task automatic run_job(input int kind, input int gap, input bit use_full,
                           input bit bp, input int abort_at);
        int  cyc, fcnt, k;
        bit  pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                stim[i*N+j] = (kind == 0) ? i + j + 1 : (kind == 2) ? 255 : int'($urandom_range(255));
            end
            stim[NN+i] = (kind == 0) ? i + 1 : (kind == 2) ? 255 : int'($urandom_range(255));
        end
        start = 1'b1;
        tick();
        start = 1'b0; jd_cnt = 0; low_cnt = 1; got.delete();
        cyc = 0; fcnt = use_full ? 5 : 0;
        while (m_acc < TOT && cyc < 3000) begin
            if (abort_at >= 0 && m_acc == abort_at) begin
                in_valid = 1'b0; start = 1'b0;
                return;
            end
            in_valid = ($urandom_range(99) >= gap);
            in_data  = DW'(stim[m_acc]);
            if (use_full && m_acc >= 3*N + 2 && m_acc < 4*N && fcnt > 0) begin
                a_full[3] = 1'b1; fcnt--;
            end else begin
                a_full[3] = 1'b0;
            end
            b_full = use_full && ($urandom_range(3) == 0);
            start  = ($urandom_range(7) == 0);
            tick();
            cyc++;
        end
        in_valid = 1'b0; a_full = '0; b_full = 1'b0; start = 1'b0;
        chk("feed_in_time", cyc < 3000, 1);
        repeat ($urandom_range(1, 4)) begin rand_c(); tick(); end
        chk("row3_count", fa[3].size(), N);
        chk("b_count", fb.size(), N);
        if (fa[3].size() == N) begin
            for (int j = 0; j < N; j++) chk("row3_order", fa[3][j], stim[3*N+j]);
        end
        for (int i = 0; i < N; i++) begin
            longint s = 0;
            if (fa[i].size() == N && fb.size() == N) begin
                for (int j = 0; j < N; j++) s += longint'(fa[i][j]) * longint'(fb[j]);
            end
            mvm_c[i] = CW'(s);
        end
        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
        k = 0;
        while (m_active && k < 400) begin
            out_ready = bp ? pat[k % 4] : 1'b1;
            start     = ($urandom_range(5) == 0);
            rand_c();
            tick();
            k++;
        end
        start = 1'b0; out_ready = 1'b0;
        chk("drain_in_time", k < 400, 1);
        repeat (3) tick();
        chk("job_done_count", jd_cnt, 1);
        chk("clear_low_cycles", low_cnt - 1, 2);
        chk("word_count", got.size(), N);
        if (kind == 0 && got.size() == N) begin
            chk("pin_model_w0", m_res[0], 204);
            chk("pin_w0", got[0], 204);
            chk("pin_w7", got[7], 456);
        end
        if (kind == 2 && got.size() == N) begin
            chk("pin_max_w0", got[0], 520200);
            chk("pin_max_w7", got[7], 520200);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; a_full = '0;
        b_full = 1'b0; mvm_done = 1'b0; out_ready = 1'b0; rand_c();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_mvm_rst_n", mvm_rst_n, 0);
        rst = 1'b0;
        tick();
        chk("post_reset_mvm_rst_n", mvm_rst_n, 1);

        run_job(0, 0, 1'b0, 1'b0, -1);
        run_job(1, 30, 1'b1, 1'b1, -1);

        run_job(1, 20, 1'b0, 1'b0, 20);
        rst = 1'b1;
        tick();
        chk("midjob_rst_busy", busy, 0);
        chk("midjob_rst_in_ready", in_ready, 0);
        chk("midjob_rst_mvm_rst_n", mvm_rst_n, 0);
        chk("midjob_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        chk("midjob_release_mvm_rst_n", mvm_rst_n, 1);
        run_job(1, 10, 1'b0, 1'b0, -1);

        run_job(2, 0, 1'b0, 1'b1, -1);
        for (int r = 0; r < 3; r++) run_job(1, 25, 1'b1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
